// File: rtl/if_fetch_queue_if.sv
// Instruction-bus handshake between the fetch queue (master) and a
// wait-state instruction memory (slave): one outstanding request at a time.
interface if_fetch_queue_if #(
  parameter int PC_W   = 30,
  parameter int INSN_W = 32
) ();
  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_ack;
  logic [INSN_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_fetch_queue.sv
// IF stage with a DEPTH-entry prefetch queue: issues fetches on the instruction
// bus and presents one {pc, insn, valid} slot to decode with stall/flush/branch.
module if_fetch_queue #(
  parameter int                PC_W         = 30,
  parameter int                INSN_W       = 32,
  parameter int                DEPTH        = 4,
  parameter logic [PC_W-1:0]   RESET_VECTOR = '0,
  parameter logic [INSN_W-1:0] NOP_INSN     = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  if_fetch_queue_if.master             bus,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [PC_W-1:0]              new_pc,
  input  logic                         br_taken,
  input  logic [PC_W-1:0]              br_addr,
  output logic [PC_W-1:0]              if_pc,
  output logic [INSN_W-1:0]            if_insn,
  output logic                         if_en,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic [INSN_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;

  logic [PC_W-1:0]   q_pc_mem   [DEPTH];
  logic [INSN_W-1:0] q_insn_mem [DEPTH];

  logic              redirect, req, accept, pop, bypass, push;
  logic [PC_W-1:0]   target;

  always_comb begin
    redirect   = flush | (br_taken & ~stall);
    target     = flush ? new_pc : br_addr;
    // Request is withdrawn during reset and in any redirect cycle.
    req        = ~reset & (count_q != FULL) & ~redirect;
    accept     = req & bus.mem_ack;
    pop        = ~stall & ~redirect & (count_q != '0);
    bypass     = ~stall & ~redirect & (count_q == '0) & accept;
    push       = accept & ~bypass;

    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if_pc_d    = if_pc_q;
    if_insn_d  = if_insn_q;
    if_en_d    = if_en_q;

    if (redirect) begin
      fetch_pc_d = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if_pc_d    = target;
      if_insn_d  = NOP_INSN;
      if_en_d    = 1'b0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (push)   wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // A stalled slot holds; otherwise the queue head has priority over bypass.
      if (!stall) begin
        if (pop) begin
          if_pc_d   = q_pc_mem[rd_ptr_q];
          if_insn_d = q_insn_mem[rd_ptr_q];
          if_en_d   = 1'b1;
        end else if (bypass) begin
          if_pc_d   = fetch_pc_q;
          if_insn_d = bus.mem_rdata;
          if_en_d   = 1'b1;
        end else begin
          if_insn_d = NOP_INSN;
          if_en_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      if_pc_q    <= RESET_VECTOR;
      if_insn_q  <= NOP_INSN;
      if_en_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if_pc_q    <= if_pc_d;
      if_insn_q  <= if_insn_d;
      if_en_q    <= if_en_d;
    end
  end

  // Queue storage is data only; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_mem[wr_ptr_q]   <= fetch_pc_q;
      q_insn_mem[wr_ptr_q] <= bus.mem_rdata;
    end
  end

  assign bus.mem_req  = req;
  assign bus.mem_addr = fetch_pc_q;
  assign if_pc        = if_pc_q;
  assign if_insn      = if_insn_q;
  assign if_en        = if_en_q;
  assign q_count      = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and randomized bench for if_fetch_queue, checked against a
// queue-based reference model of the fetch/decode contract.
module tb_if_fetch_queue;

  localparam int                PC_W   = 30;
  localparam int                INSN_W = 32;
  localparam int                DEPTH  = 4;
  localparam int                CNT_W  = $clog2(DEPTH+1);
  localparam logic [PC_W-1:0]   RV     = '0;
  localparam logic [INSN_W-1:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              reset;
  logic              stall, flush, br_taken;
  logic [PC_W-1:0]   new_pc, br_addr;
  logic [PC_W-1:0]   if_pc;
  logic [INSN_W-1:0] if_insn;
  logic              if_en;
  logic [CNT_W-1:0]  q_count;

  if_fetch_queue_if #(.PC_W(PC_W), .INSN_W(INSN_W)) bus ();

  if_fetch_queue #(
    .PC_W(PC_W), .INSN_W(INSN_W), .DEPTH(DEPTH),
    .RESET_VECTOR(RV), .NOP_INSN(NOP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } ent_t;

  ent_t              m_q[$];
  logic [PC_W-1:0]   m_fpc, m_pc;
  logic [INSN_W-1:0] m_insn;
  logic              m_en;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc  = RV;
    m_pc   = RV;
    m_insn = NOP;
    m_en   = 1'b0;
  endtask

  task automatic chk_slot(input string tag);
    chk({tag, ".if_en"},   64'(if_en),   64'(m_en));
    chk({tag, ".if_pc"},   64'(if_pc),   64'(m_pc));
    chk({tag, ".if_insn"}, 64'(if_insn), 64'(m_insn));
    chk({tag, ".q_count"}, 64'(q_count), 64'(m_q.size()));
  endtask

  // One clock cycle: drive, check the request side, clock, advance the model, check the slot.
  task automatic step(input logic s, input logic f, input logic b, input logic a,
                      input logic [PC_W-1:0] np, input logic [PC_W-1:0] ba);
    logic              redir, exp_req, acc;
    logic [INSN_W-1:0] rd;
    logic [PC_W-1:0]   tgt;
    ent_t              e;
    stall         = s;
    flush         = f;
    br_taken      = b;
    bus.mem_ack   = a;
    new_pc        = np;
    br_addr       = ba;
    rd            = INSN_W'($urandom);
    bus.mem_rdata = rd;
    #1;
    redir   = f || (b && !s);
    tgt     = f ? np : ba;
    exp_req = !redir && (m_q.size() < DEPTH);
    acc     = exp_req && a;
    chk("mem_req",  64'(bus.mem_req),  64'(exp_req));
    chk("mem_addr", 64'(bus.mem_addr), 64'(m_fpc));
    @(posedge clk);
    if (redir) begin
      m_q.delete();
      m_fpc  = tgt;
      m_pc   = tgt;
      m_insn = NOP;
      m_en   = 1'b0;
    end else begin
      if (!s) begin
        if (m_q.size() > 0) begin
          e      = m_q.pop_front();
          m_pc   = e.pc;
          m_insn = e.insn;
          m_en   = 1'b1;
          if (acc) m_q.push_back({m_fpc, rd});
        end else if (acc) begin
          m_pc   = m_fpc;
          m_insn = rd;
          m_en   = 1'b1;
        end else begin
          m_insn = NOP;
          m_en   = 1'b0;
        end
      end else if (acc) begin
        m_q.push_back({m_fpc, rd});
      end
      if (acc) m_fpc = m_fpc + 1'b1;
    end
    #1;
    chk_slot("slot");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    br_taken    = 1'b0;
    new_pc      = '0;
    br_addr     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    model_reset();

    // Reset state
    #1;
    chk("rst.mem_req", 64'(bus.mem_req), 64'(0));
    chk_slot("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Ack tied high, no stall: bypass stream
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Stall 6 cycles with ack high fills the queue, then drain
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("full.q_count", 64'(q_count), 64'(DEPTH));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Ack every third cycle
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, (i % 3 == 2), '0, '0);

    // Three queued entries, then flush under stall with a same-cycle ack
    step(1'b0, 1'b1, 1'b0, 1'b0, 30'h10, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("pre_flush.q_count", 64'(q_count), 64'(3));
    step(1'b1, 1'b1, 1'b0, 1'b1, 30'h100, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Branch ignored under stall, taken without stall
    step(1'b1, 1'b0, 1'b1, 1'b1, '0, 30'h40);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0, 30'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Flush and branch together: flush target wins
    step(1'b0, 1'b1, 1'b1, 1'b1, 30'h200, 30'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 6, $urandom_range(0, 1) == 1,
           PC_W'($urandom), PC_W'($urandom));

    // Asynchronous reset mid-burst with two queued entries
    step(1'b0, 1'b1, 1'b0, 1'b0, 30'h300, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("pre_reset.q_count", 64'(q_count), 64'(2));
    bus.mem_ack = 1'b1;
    stall       = 1'b0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst.mem_req",  64'(bus.mem_req),  64'(0));
    chk("async_rst.mem_addr", 64'(bus.mem_addr), 64'(RV));
    chk_slot("async_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 9) < 3, 1'b0, $urandom_range(0, 99) < 5,
           $urandom_range(0, 1) == 1, '0, PC_W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised successor of the IF/ID pipeline register. It generates the fetch PC, issues requests to a wait-state instruction bus, and buffers returned instructions in a DEPTH-entry prefetch queue. It presents one {pc, insn, valid} slot to decode, with stall, flush and branch redirect control. It sits between the instruction bus interface and the ID stage. Its output contract toward decode is the same as the single-register IF stage.

Parameters:
PC_W, 30, word-address width of PC.
INSN_W, 32, instruction width.
DEPTH, 4, prefetch queue entries; power of two, >= 2.
RESET_VECTOR, 0, PC value after reset.
NOP_INSN, 0, instruction value driven when the output slot is invalid.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
mem_req  out  1  fetch request.
mem_addr  out  PC_W  fetch word address; equals fetch_pc.
mem_ack  in  1  request completed this cycle; mem_rdata valid.
mem_rdata  in  INSN_W  fetched instruction.
stall  in  1  hold the output slot.
flush  in  1  redirect to new_pc and discard everything.
new_pc  in  PC_W  flush target.
br_taken  in  1  branch redirect.
br_addr  in  PC_W  branch target.
if_pc  out  PC_W  PC of the presented instruction.
if_insn  out  INSN_W  presented instruction.
if_en  out  1  output slot valid.
q_count  out  clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (asynchronous, active-high; clock domain clk):
  - fetch_pc = RESET_VECTOR, queue empty, q_count = 0.
  - if_pc = RESET_VECTOR, if_insn = NOP_INSN, if_en = 0.
  - mem_req = 0 while reset is asserted.
  - Reset asserted mid-operation drops all queue contents and any outstanding request immediately.
- Request generation:
  - mem_req = (q_count < DEPTH) and no redirect in this cycle. mem_req is combinational from registered state plus flush/br_taken.
  - mem_addr = fetch_pc and is held stable until mem_ack.
  - Only one request is outstanding at a time. The bus must tolerate mem_req being withdrawn on a redirect.
- On mem_ack with mem_req high and no redirect:
  - fetch_pc increments by 1, wrapping modulo 2^PC_W.
  - {fetch_pc, mem_rdata} is pushed to the queue, unless it is bypassed (see below).
  - mem_ack while mem_req is low is ignored.
- Output slot update, when stall = 0 and no redirect:
  - Queue non-empty: pop the head into if_pc/if_insn; if_en = 1.
  - Queue empty and mem_ack this cycle: bypass {mem_addr, mem_rdata} straight into the slot; if_en = 1. Latency is ack to if_en = 1 cycle.
  - Otherwise: if_en = 0, if_insn = NOP_INSN, if_pc holds.
- stall = 1:
  - The output slot holds all three values.
  - The queue still accepts acks while q_count < DEPTH.
- Redirect priority: flush > br_taken > normal.
  - flush acts regardless of stall. br_taken acts only when stall = 0; it is ignored when stall = 1.
  - Redirect cycle: queue cleared, any ack in the same cycle is discarded, fetch_pc <= new_pc (flush) or br_addr (branch).
  - Redirect cycle output slot: if_en = 0, if_insn = NOP_INSN, if_pc <= target.
  - First request to the target is issued the following cycle.
- Queue pointers:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - A simultaneous push and pop leaves q_count unchanged.
  - A push when full cannot occur, because mem_req is low when q_count = DEPTH.
  - A pop that frees a slot from full re-enables mem_req in the next cycle.
- q_count is never greater than DEPTH.

Test Plan:
- Reset release, mem_ack tied high, stall = 0: mem_req = 1 with mem_addr = 0 in the first cycle. Cycle 2 shows if_pc = 0, if_en = 1, then if_pc = 1, 2, 3 on consecutive cycles. q_count stays 0 (bypass path).
- stall = 1 for 6 cycles with ack always high, DEPTH = 4:
  - q_count rises to 4, then mem_req = 0 with mem_addr held.
  - Release stall: slot shows pcs in order with no gaps or duplicates.
  - mem_req reasserts one cycle after the first pop.
- mem_ack asserted only every 3rd cycle, stall = 0: if_en pulses one cycle after each ack; if_insn = NOP_INSN and if_pc holds in between.
- Queue holds 3 entries and flush = 1 with new_pc = 0x100 while stall = 1 and an ack arrives in the same cycle:
  - Next cycle: q_count = 0, if_en = 0, if_pc = 0x100.
  - The next request has mem_addr = 0x100; the discarded data never appears.
- br_taken = 1 with br_addr = 0x40 and stall = 1: ignored. Same with stall = 0: redirect to 0x40.
- flush and br_taken asserted together: the new_pc target wins.
- Reset asserted mid-burst with q_count = 2: all outputs return to reset values asynchronously, before the next clock edge.
